// File: rtl/uart_mem_loader.sv
// uart_mem_loader: UART boot loader. Receives a little-endian 32-bit length followed by the
// payload, writes each payload byte to memory at LOAD_ADDR + index and holds the core in reset
// until the image is complete.
// Optional macro LOADER_CHECKSUM_EN: a trailing byte equal to the 8-bit sum of the payload is
// required before the core is released; a mismatch aborts the load.
module uart_mem_loader #(
  parameter int unsigned CLOCK_RATE = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter logic [31:0] LOAD_ADDR  = 32'h0000_0000,
  parameter int unsigned MAX_BYTES  = 65536
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_rstn
);

  localparam int unsigned BIT_CYCLES = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned HALF       = BIT_CYCLES / 2;
  localparam int unsigned CntW       = $clog2(BIT_CYCLES + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BIT_CYCLES - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  typedef enum logic [2:0] {
    LdLen,
    LdData,
`ifdef LOADER_CHECKSUM_EN
    LdChk,
`endif
    LdDone,
    LdError
  } ld_state_e;

  logic [1:0]      rx_sync;
  logic            rx_s;
  logic            rx_prev;
  rx_state_e       rx_state;
  logic [CntW-1:0] rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            byte_valid;
  logic            frame_err;

  ld_state_e       ld_state;
  logic [1:0]      len_cnt;
  logic [31:0]     len_q;
  logic [31:0]     len_next;
  logic [31:0]     idx;
  logic [31:0]     wr_addr;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      sum;
`endif

  assign rx_s     = rx_sync[1];
  assign len_next = {rx_shift, len_q[31:8]};
  assign wr_addr  = LOAD_ADDR + idx;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_prev <= rx_sync[1];
    end
  end

  // UART receiver: mid-bit sampling, LSB first, one-cycle byte_valid / frame_err pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state   <= RxIdle;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        // Requires a high-to-low transition, so a held-low line cannot retrigger.
        RxIdle: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RxStart;
            rx_cnt   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt == HalfLast) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RxIdle : RxData;
          end else begin
            rx_cnt <= rx_cnt + CntW'(1);
          end
        end
        RxData: begin
          if (rx_cnt == BitLast) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RxStop;
          end else begin
            rx_cnt <= rx_cnt + CntW'(1);
          end
        end
        RxStop: begin
          if (rx_cnt == BitLast) begin
            rx_cnt     <= '0;
            byte_valid <= rx_s;
            frame_err  <= !rx_s;
            rx_state   <= RxIdle;
          end else begin
            rx_cnt <= rx_cnt + CntW'(1);
          end
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

  // Loader: length collection, byte writes and the sticky done/error outcome.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ld_state  <= LdLen;
      len_cnt   <= '0;
      len_q     <= '0;
      idx       <= '0;
      mem_write <= 1'b0;
      mem_wmask <= '0;
      mem_wdata <= '0;
      mem_addr  <= LOAD_ADDR;
      busy      <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_rstn  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      mem_write <= 1'b0;
      case (ld_state)
        LdLen: begin
          if (frame_err) begin
            ld_state <= LdError;
            error    <= 1'b1;
          end else if (byte_valid) begin
            len_q   <= len_next;
            len_cnt <= len_cnt + 2'd1;
            if (len_cnt == 2'd3) begin
              idx <= '0;
`ifdef LOADER_CHECKSUM_EN
              sum <= '0;
`endif
              if (len_next == '0) begin
`ifdef LOADER_CHECKSUM_EN
                ld_state <= LdChk;
`else
                ld_state <= LdDone;
`endif
              end else if (len_next > 32'(MAX_BYTES)) begin
                ld_state <= LdError;
                error    <= 1'b1;
              end else begin
                ld_state <= LdData;
              end
            end
          end
        end
        LdData: begin
          if (frame_err) begin
            ld_state <= LdError;
            error    <= 1'b1;
          end else if (byte_valid) begin
            mem_write <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wmask <= 4'b0001 << wr_addr[1:0];
            mem_wdata <= {4{rx_shift}};
            idx       <= idx + 32'd1;
`ifdef LOADER_CHECKSUM_EN
            sum       <= sum + rx_shift;
            if (idx == len_q - 32'd1) ld_state <= LdChk;
`else
            if (idx == len_q - 32'd1) ld_state <= LdDone;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        LdChk: begin
          if (frame_err || (byte_valid && rx_shift != sum)) begin
            ld_state <= LdError;
            error    <= 1'b1;
          end else if (byte_valid) begin
            ld_state <= LdDone;
          end
        end
`endif
        // Release the memory port first; the core leaves reset one cycle after done rises.
        LdDone: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          cpu_rstn <= done;
        end
        LdError: ;
        default: ld_state <= LdError;
      endcase
    end
  end

endmodule
